// File: rtl/mips_muldiv_unit.sv
// MIPS HI/LO multiply/divide unit.
// Iterative shift-add multiply and restoring divide, one bit per cycle,
// operating on magnitudes with sign correction applied when HI/LO are loaded.
// MTHI/MTLO writes are accepted only while idle.
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic                 is_div_reg;
    logic                 sign_a_reg;
    logic                 sign_b_reg;
    logic [WIDTH-1:0]     operand_reg;   // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]   acc_reg;       // {partial product, multiplier} or {remainder, quotient}
    logic [CW-1:0]        count_reg;

    // Operand decode at the accepting edge
    logic             sign_a_in;
    logic             sign_b_in;
    logic [WIDTH-1:0] mag_a_in;
    logic [WIDTH-1:0] mag_b_in;
    logic             div_zero_in;

    // One iteration and the sign-corrected result of the final iteration
    logic [WIDTH:0]     mul_addend;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] step_next;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    // Decode signs and magnitudes of the incoming operands
    always_comb begin
        sign_a_in   = ~op[0] & a[WIDTH-1];
        sign_b_in   = ~op[0] & b[WIDTH-1];
        mag_a_in    = sign_a_in ? -a : a;
        mag_b_in    = sign_b_in ? -b : b;
        div_zero_in = op[1] & (b == '0);
    end

    // Next accumulator value for one multiply or divide step, plus final result
    always_comb begin
        mul_addend = acc_reg[0] ? {1'b0, operand_reg} : '0;
        mul_sum    = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + mul_addend;
        mul_next   = {mul_sum, acc_reg[WIDTH-1:1]};

        // Bit WIDTH of the trial difference is the borrow: set means restore
        div_trial  = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]} - {1'b0, operand_reg};
        div_next   = div_trial[WIDTH] ? {acc_reg[2*WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};

        step_next  = is_div_reg ? div_next : mul_next;

        product    = (sign_a_reg ^ sign_b_reg) ? -step_next : step_next;
        quotient   = (sign_a_reg ^ sign_b_reg) ? -step_next[WIDTH-1:0] : step_next[WIDTH-1:0];
        remainder  = sign_a_reg ? -step_next[2*WIDTH-1:WIDTH] : step_next[2*WIDTH-1:WIDTH];

        res_hi     = is_div_reg ? remainder : product[2*WIDTH-1:WIDTH];
        res_lo     = is_div_reg ? quotient  : product[WIDTH-1:0];
    end

    // Control FSM, iteration datapath and HI/LO registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            is_div_reg  <= 1'b0;
            sign_a_reg  <= 1'b0;
            sign_b_reg  <= 1'b0;
            operand_reg <= '0;
            acc_reg     <= '0;
            count_reg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        is_div_reg <= op[1];
                        sign_a_reg <= sign_a_in;
                        sign_b_reg <= sign_b_in;
                        count_reg  <= '0;
                        if (div_zero_in) begin
                            // Divide by zero completes immediately; overrides any MTHI/MTLO
                            state       <= DONE;
                            done        <= 1'b1;
                            div_by_zero <= 1'b1;
                            hi          <= a;
                            lo          <= '1;
                            operand_reg <= '0;
                            acc_reg     <= '0;
                        end else begin
                            state       <= RUN;
                            busy        <= 1'b1;
                            div_by_zero <= 1'b0;
                            operand_reg <= op[1] ? mag_b_in : mag_a_in;
                            acc_reg     <= {{WIDTH{1'b0}}, (op[1] ? mag_a_in : mag_b_in)};
                        end
                    end
                end
                RUN: begin
                    acc_reg   <= step_next;
                    count_reg <= count_reg + 1'b1;
                    if (count_reg == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        hi    <= res_hi;
                        lo    <= res_lo;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit (WIDTH=32).
// A cycle-level behavioural model computes results with plain 64-bit
// arithmetic; a compare process checks every cycle, and directed cases
// pin literal expectations.
module tb_mips_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    int checks;
    int failures;

    mips_muldiv_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: returns {hi, lo}
    function automatic logic [63:0] model_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        longint unsigned ux, uy, p;
        logic [63:0] res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            2'd0: res = 64'(sx * sy);
            2'd1: begin p = ux * uy; res = p; end
            2'd2: begin q = sx / sy; r = sx % sy; res = {r[31:0], q[31:0]}; end
            default: res = {x % y, x / y};
        endcase
        return res;
    endfunction

    // Behavioural model: remaining busy cycles, pending result, done flag
    logic [31:0] m_hi, m_lo;
    logic        m_dbz;
    logic        m_done;
    int          m_left;
    logic [63:0] m_pend;

    // Model update on each clock edge, cleared by asynchronous reset
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_hi = 0; m_lo = 0; m_dbz = 0; m_done = 0; m_left = 0; m_pend = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                {m_hi, m_lo} = m_pend;
                m_done = 1;
            end
        end else begin
            if (hi_we) m_hi = wdata;
            if (lo_we) m_lo = wdata;
            if (start) begin
                if (op[1] && b == 32'd0) begin
                    m_hi = a; m_lo = 32'hFFFF_FFFF; m_dbz = 1; m_done = 1;
                end else begin
                    m_dbz = 0;
                    m_pend = model_result(op, a, b);
                    m_left = 32;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        check("busy", 64'(busy), 64'(m_left > 0));
        check("done", 64'(done), 64'(m_done));
        check("hi", 64'(hi), 64'(m_hi));
        check("lo", 64'(lo), 64'(m_lo));
        check("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
    end

    // Called at posedge+2: request, then scramble inputs after the accepting edge
    task automatic launch(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
        start = 1; op = o; a = av; b = bv; hi_we = 0; lo_we = 0;
        @(posedge clk); #2;
        start = 0; op = 2'($urandom); a = $urandom; b = $urandom;
    endtask

    // Wait for done (bounded), then check latency, busy length and results
    task automatic finish_op(input string name, input logic [31:0] eh, input logic [31:0] el,
                             input logic edbz, input int elat);
        int k, nbusy;
        k = 0; nbusy = 0;
        while (!done && k < 100) begin
            if (busy) nbusy++;
            @(posedge clk); #2;
            k++;
        end
        check({name, "_done_seen"}, 64'(done), 64'(1));
        check({name, "_latency"}, 64'(k), 64'(elat));
        check({name, "_busy_cycles"}, 64'(nbusy), 64'(elat));
        check({name, "_hi"}, 64'(hi), 64'(eh));
        check({name, "_lo"}, 64'(lo), 64'(el));
        check({name, "_dbz"}, 64'(div_by_zero), 64'(edbz));
        @(posedge clk); #2;
        check({name, "_done_single"}, 64'(done), 64'(0));
    endtask

    initial begin
        int dcount;
        logic [31:0] hold_hi;
        checks = 0; failures = 0;
        rst = 0; start = 0; op = 0; a = 0; b = 0; hi_we = 0; lo_we = 0; wdata = 0;
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        check("rst_dbz", 64'(div_by_zero), 64'(0));
        check("model_mult", model_result(2'd0, 32'hFFFF_FFFD, 32'd5), 64'hFFFF_FFFF_FFFF_FFF1);
        check("model_divu", model_result(2'd3, 32'd100, 32'd7), {32'd2, 32'd14});
        check("model_div_ovf", model_result(2'd2, 32'h8000_0000, 32'hFFFF_FFFF), {32'd0, 32'h8000_0000});
        repeat (2) @(posedge clk);
        #2 rst = 1;

        // Start in the same cycle reset is released is accepted on the next edge
        launch(2'd0, 32'hFFFF_FFFD, 32'h0000_0005);
        finish_op("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 32);
        launch(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        finish_op("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 32);
        launch(2'd2, 32'hFFFF_FFF9, 32'h0000_0002);
        finish_op("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 32);
        launch(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        finish_op("div_ovf", 32'h0000_0000, 32'h8000_0000, 1'b0, 32);
        launch(2'd3, 32'd100, 32'd0);
        finish_op("divu_zero", 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 0);
        launch(2'd1, 32'd2, 32'd3);
        finish_op("multu_small", 32'd0, 32'd6, 1'b0, 32);

        // MTHI/MTLO while idle
        hi_we = 1; lo_we = 1; wdata = 32'hA5A5_0F0F;
        @(posedge clk); #2;
        hi_we = 0; lo_we = 0;
        check("mt_both_hi", 64'(hi), 64'h0000_0000_A5A5_0F0F);
        check("mt_both_lo", 64'(lo), 64'h0000_0000_A5A5_0F0F);

        // MTHI and a second start during RUN are both ignored
        hold_hi = hi;
        launch(2'd1, 32'd7, 32'd9);
        dcount = 0;
        repeat (3) @(posedge clk);
        #0;
        hi_we = 1; wdata = 32'hDEAD_BEEF; start = 1; op = 2'd3; a = 32'd1; b = 32'd0;
        @(posedge clk); #2;
        hi_we = 0; start = 0;
        check("run_mthi_ignored", 64'(hi), 64'(hold_hi));
        for (int i = 0; i < 40; i++) begin
            if (done) dcount++;
            @(posedge clk); #2;
        end
        check("run_single_done", 64'(dcount), 64'(1));
        check("run_result_lo", 64'(lo), 64'd63);
        check("run_result_hi", 64'(hi), 64'd0);

        // Reset during RUN cycle 10
        launch(2'd0, 32'h1234_5678, 32'h0000_0010);
        repeat (9) @(posedge clk);
        #2 rst = 0;
        #1;
        check("rstmid_busy", 64'(busy), 64'(0));
        check("rstmid_done", 64'(done), 64'(0));
        check("rstmid_hi", 64'(hi), 64'(0));
        check("rstmid_lo", 64'(lo), 64'(0));
        @(posedge clk); #2 rst = 1;
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dcount++;
            @(posedge clk); #2;
        end
        check("rstmid_no_done", 64'(dcount), 64'(0));
        launch(2'd3, 32'd1000, 32'd7);
        finish_op("post_rst_divu", 32'd6, 32'd142, 1'b0, 32);

        // Randomized traffic checked by the per-cycle model comparison
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 3) == 0);
            op    = 2'($urandom_range(0, 3));
            a     = $urandom;
            b     = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'd1;
                3: a = 32'd0;
                4: b = 32'(signed'(-$urandom_range(1, 20)));
                default: ;
            endcase
            hi_we = ($urandom_range(0, 5) == 0);
            lo_we = ($urandom_range(0, 5) == 0);
            wdata = $urandom;
            @(posedge clk); #2;
        end
        start = 0; hi_we = 0; lo_we = 0;
        repeat (40) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
